// File: rtl/fp_out_stage.sv
// DES output stage: inverse initial permutation of {R16, L16} into a 2-entry FIFO.
// Define FP_BYTE_SERIAL_EN to emit each block as 8 byte beats instead of one 64-bit beat.
module fp_out_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:32] left_in,
    input  logic [1:32] right_in,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef FP_BYTE_SERIAL_EN
    output logic [1:8]  data_out,
`else
    output logic [1:64] data_out,
`endif
    output logic        out_last
);

    localparam int unsigned BLK_W = 64;
`ifdef FP_BYTE_SERIAL_EN
    localparam int unsigned OUT_W = 8;
`else
    localparam int unsigned OUT_W = 64;
`endif

    // Output bit i (1-based, MSB first) takes preoutput bit FP_TAB[i-1].
    localparam int unsigned FP_TAB [BLK_W] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    logic [1:BLK_W]   preout_c;
    logic [BLK_W-1:0] perm_c;

    assign preout_c = {right_in, left_in};

    for (genvar i = 0; i < BLK_W; i++) begin : g_fp
        assign perm_c[BLK_W-1-i] = preout_c[FP_TAB[i]];
    end

    logic [BLK_W-1:0] mem_q [2];
    logic [BLK_W-1:0] mem_n [2];
    logic             wr_ptr_q, wr_ptr_n;
    logic             rd_ptr_q, rd_ptr_n;
    logic [1:0]       count_q, count_n;
    logic             in_ready_n;
    logic             out_valid_n;
    logic             out_last_n;
    logic [OUT_W-1:0] data_n;
    logic [BLK_W-1:0] head_c;
    logic             push_c;
    logic             take_c;
    logic             pop_c;
`ifdef FP_BYTE_SERIAL_EN
    logic [2:0]       beat_q, beat_n;
    logic [BLK_W-1:0] head_sh_c;
`endif

    assign push_c = in_valid && in_ready;
    assign take_c = out_valid && out_ready;
`ifdef FP_BYTE_SERIAL_EN
    assign pop_c  = take_c && (beat_q == 3'd7);
`else
    assign pop_c  = take_c;
`endif

    // Next FIFO state, then the registered output view of its head.
    always_comb begin
        mem_n    = mem_q;
        wr_ptr_n = wr_ptr_q;
        rd_ptr_n = rd_ptr_q;
        count_n  = count_q;
`ifdef FP_BYTE_SERIAL_EN
        beat_n   = beat_q;
        if (take_c) begin
            beat_n = beat_q + 3'd1;
        end
`endif
        if (push_c) begin
            mem_n[wr_ptr_q] = perm_c;
            wr_ptr_n        = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_n = ~rd_ptr_q;
        end
        case ({push_c, pop_c})
            2'b10:   count_n = count_q + 2'd1;
            2'b01:   count_n = count_q - 2'd1;
            default: count_n = count_q;
        endcase

        head_c      = mem_n[rd_ptr_n];
        out_valid_n = (count_n != 2'd0);
        in_ready_n  = (count_n < 2'd2);
`ifdef FP_BYTE_SERIAL_EN
        head_sh_c   = head_c << {beat_n, 3'b000};
        data_n      = head_sh_c[BLK_W-1 -: OUT_W];
        out_last_n  = out_valid_n && (beat_n == 3'd7);
`else
        data_n      = head_c;
        out_last_n  = out_valid_n;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            data_out  <= '0;
`ifdef FP_BYTE_SERIAL_EN
            beat_q    <= 3'd0;
`endif
        end else begin
            mem_q     <= mem_n;
            wr_ptr_q  <= wr_ptr_n;
            rd_ptr_q  <= rd_ptr_n;
            count_q   <= count_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            data_out  <= data_n;
`ifdef FP_BYTE_SERIAL_EN
            beat_q    <= beat_n;
`endif
        end
    end

endmodule

// File: tb/tb_fp_out_stage.sv
// Bench for fp_out_stage: a block-level scoreboard (FP undoes IP, so the expected block is the
// original plaintext) checked every cycle, plus the textbook DES final-round vector as literals.
module tb_fp_out_stage;

`ifdef FP_BYTE_SERIAL_EN
    localparam int BEATS = 8;
    localparam int OW    = 8;
    localparam int N_RT  = 1000;
`else
    localparam int BEATS = 1;
    localparam int OW    = 64;
    localparam int N_RT  = 10000;
`endif
    localparam logic [63:0] KV = 64'h85E813540F0AB405;
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:32]   left_in;
    logic [1:32]   right_in;
    logic          out_valid;
    logic          out_ready;
    logic [1:OW]   data_out;
    logic          out_last;

    int            checks = 0;
    int            failures = 0;
    int            acc_cnt = 0;
    int            acc_runs = 0;
    int            take_cnt = 0;
    int            take_runs = 0;
    int            last_cnt = 0;
    int            beat_m = 0;
    bit            prev_take = 1'b0;
    bit            prev_acc = 1'b0;
    bit            run_ok = 1'b0;
    bit            rt_on = 1'b0;
    logic [63:0]   cur_exp = '0;
    logic [63:0]   exp_q [$];

    fp_out_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .left_in   (left_in),
        .right_in  (right_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] r = '0;
        for (int i = 0; i < 64; i++) r = {r[62:0], x[6'(64 - IP_T[i])]};
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard bookkeeping on each rising edge (pre-update values).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            beat_m    = 0;
            run_ok    = 1'b0;
            prev_take = 1'b0;
            prev_acc  = 1'b0;
        end else begin
            run_ok = 1'b1;
            if (out_valid && out_ready) begin
                if (!prev_take) take_runs++;
                take_cnt++;
                if (out_last) last_cnt++;
                if (beat_m == BEATS - 1) begin
                    beat_m = 0;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    beat_m++;
                end
            end
            prev_take = out_valid && out_ready;
            if (in_valid && in_ready) begin
                if (!prev_acc) acc_runs++;
                acc_cnt++;
                exp_q.push_back(cur_exp);
            end
            prev_acc = in_valid && in_ready;
        end
    end

    // Every cycle: outputs must match the head of the expected-block queue.
    task automatic compare();
        logic [63:0] sh;
        if (rst_n && run_ok) begin
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            if (exp_q.size() != 0) begin
                sh = exp_q[0] << (8 * beat_m);
`ifdef FP_BYTE_SERIAL_EN
                check("data_out", 64'(data_out), 64'(sh[63:56]));
`else
                check("data_out", 64'(data_out), sh);
`endif
                check("out_last", 64'(out_last), 64'(beat_m == BEATS - 1));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        if (rt_on) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_raw(input logic [31:0] l, input logic [31:0] r, input logic [63:0] x);
        int start;
        bit ok;
        start    = acc_cnt;
        ok       = 1'b0;
        in_valid = 1'b1;
        left_in  = l;
        right_in = r;
        cur_exp  = x;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (acc_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 64'(ok), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [63:0] x);
        logic [63:0] ip;
        ip = ip_perm(x);
        send_raw(ip[31:0], ip[63:32], x);
    endtask

    task automatic drain(input int lim);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("drain_timeout", 64'(ok), 64'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
    endtask

    initial begin
        logic [63:0] x2;
        logic [63:0] ip;
        logic [63:0] sh;
        int a0, tc0, tr0, lc0, ar0;
        bit ok;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        left_in   = '0;
        right_in  = '0;
        repeat (3) tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Textbook DES final-round vector.
        send_raw(32'h43423234, 32'h0A4CD995, KV);
`ifdef FP_BYTE_SERIAL_EN
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sh = KV << (8 * k);
            check("kv_byte", 64'(data_out), 64'(sh[63:56]));
            check("kv_last", 64'(out_last), 64'(k == 7));
            tick();
        end
`else
        check("kv_data", 64'(data_out), KV);
        check("kv_last", 64'(out_last), 64'd1);
        out_ready = 1'b1;
        tick();
`endif
        drain(100);

        // Backpressure: two accepted, third held until the consumer drains.
        out_ready = 1'b0;
        send({$urandom, $urandom});
        send({$urandom, $urandom});
        x2       = {$urandom, $urandom};
        ip       = ip_perm(x2);
        a0       = acc_cnt;
        in_valid = 1'b1;
        left_in  = ip[31:0];
        right_in = ip[63:32];
        cur_exp  = x2;
        repeat (4) tick();
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_buffered", 64'(exp_q.size()), 64'd2);
        check("bp_third_held", 64'(acc_cnt - a0), 64'd0);
        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (acc_cnt != a0) begin
                ok = 1'b1;
                break;
            end
        end
        check("bp_third_accepted", 64'(ok), 64'd1);
        in_valid = 1'b0;
        drain(100);

        // Full-rate streaming of 100 blocks.
        tc0 = take_cnt;
        tr0 = take_runs;
        lc0 = last_cnt;
        ar0 = acc_runs;
        for (int i = 0; i < 100; i++) send({$urandom, $urandom});
        drain(2000);
        check("stream_beats", 64'(take_cnt - tc0), 64'(100 * BEATS));
        check("stream_contiguous", 64'(take_runs - tr0), 64'd1);
        check("stream_lasts", 64'(last_cnt - lc0), 64'd100);
`ifndef FP_BYTE_SERIAL_EN
        check("stream_accept_per_cycle", 64'(acc_runs - ar0), 64'd1);
`endif

        // Round trip with random consumer stalls.
        rt_on = 1'b1;
        for (int i = 0; i < N_RT; i++) send({$urandom, $urandom});
        rt_on = 1'b0;
        out_ready = 1'b1;
        drain(5000);

        // Reset in the middle of buffered / partially sent blocks.
        out_ready = 1'b0;
        send({$urandom, $urandom});
        send({$urandom, $urandom});
`ifdef FP_BYTE_SERIAL_EN
        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (beat_m == 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_block_reached", 64'(ok), 64'd1);
`endif
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check("no_resume_after_reset", 64'(out_valid), 64'd0);
        send_raw(32'h43423234, 32'h0A4CD995, KV);
`ifdef FP_BYTE_SERIAL_EN
        check("post_reset_first_byte", 64'(data_out), 64'h85);
`else
        check("post_reset_block", 64'(data_out), KV);
`endif
        drain(100);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_out_stage.md
FP_OUT_STAGE -- requirements
Module: fp_out_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk in 1 (rising-edge), rst_n in 1 (asynchronous, active-low).
REQ-002 SHALL provide: in_valid in 1, final-round block offered; in_ready out 1, stage can accept.
REQ-003 SHALL provide: left_in in [1:32], L16; right_in in [1:32], R16; bit 1 is the MSB, per the codebase's DES bit numbering.
REQ-004 SHALL provide: out_valid out 1, output beat available; out_ready in 1, consumer accepts the beat.
REQ-005 SHALL provide: data_out out [1:64] (parallel build) or [1:8] (serial build), plus out_last out 1, marking the final beat of a block.

Function
REQ-006 SHALL form the preoutput {right_in, left_in}: preout[1:32]=right_in, preout[33:64]=left_in.
REQ-007 SHALL apply the DES inverse initial permutation to the preoutput: out[i]=preout[FP[i]].
REQ-008 FP row 1, out 1-8: 40 8 48 16 56 24 64 32.
REQ-009 FP row 2, out 9-16: 39 7 47 15 55 23 63 31.
REQ-010 FP row 3, out 17-24: 38 6 46 14 54 22 62 30.
REQ-011 FP row 4, out 25-32: 37 5 45 13 53 21 61 29.
REQ-012 FP rows 5-8, out 33-64: 36 4 44 12 52 20 60 28 / 35 3 43 11 51 19 59 27 / 34 2 42 10 50 18 58 26 / 33 1 41 9 49 17 57 25.
REQ-013 SHALL accept a block on a clock edge where in_valid and in_ready are both 1; left_in and right_in are sampled on that edge only.
REQ-014 SHALL store the permuted blocks in a 2-entry FIFO, with in_ready = (occupancy < 2); in_ready SHALL NOT depend combinationally on out_ready.
REQ-015 SHALL assert out_valid on the cycle after acceptance into an empty FIFO (latency 1); there is no combinational path from inputs to data_out.
REQ-016 SHALL hold data_out, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-017 SHALL keep occupancy unchanged, and the data in order, on a simultaneous accept and final-beat pop when full.
REQ-018 SHALL free an entry after the last beat of its block is taken; FIFO pointers wrap modulo 2.
REQ-019 SHALL tolerate in_valid asserted while full: no accept, no data corruption.

Reset
REQ-020 SHALL, while rst_n=0, clear to: out_valid=0, out_last=0, data_out=0, occupancy=0, pointers=0, beat counter=0, and in_ready=0.
REQ-021 SHALL drive in_ready=1 from the first clock edge after rst_n deasserts.
REQ-022 SHALL discard any partially transmitted or buffered block when reset is applied mid-operation; no beat resumes after reset.

Configuration
REQ-023 Macro FP_BYTE_SERIAL_EN selects the output mode.
REQ-024 Without the macro: data_out is [1:64], one beat per block, and out_last=1 whenever out_valid=1.
REQ-025 With the macro: data_out is [1:8] and each block is sent as 8 beats, bits 1-8 first and bits 57-64 last.
REQ-026 With the macro: a 3-bit beat counter advances on each out_valid&&out_ready and wraps 7->0; out_last=1 on beat 7 only.
REQ-027 With the macro: the next block's first beat follows beat 7 with no idle cycle if one is buffered.

Verification
REQ-028 Known vector: left_in=32'h43423234, right_in=32'h0A4CD995 -> data_out=64'h85E813540F0AB405 one cycle later (serial build: bytes 85,E8,13,54,0F,0A,B4,05, out_last on byte 05).
REQ-029 Round trip: for random x, drive left_in=IP-right(x) and right_in=IP-left(x) -> data_out=x for 10,000 vectors.
REQ-030 Backpressure: out_ready=0 while 3 blocks are offered -> 2 are accepted, in_ready=0, and the third is held; release -> all 3 emerge in order and unchanged.
REQ-031 Full streaming: out_ready=1 and in_valid=1 for 100 blocks -> parallel build gives one block per cycle; serial build gives 800 contiguous beats with out_last every 8th beat.
REQ-032 Reset mid-block (serial build): assert rst_n=0 after beat 3 -> out_valid=0 immediately; after release the next block starts at beat 0.
REQ-033 Simultaneous push and pop with the FIFO full -> occupancy stays 2 and no block is lost or duplicated.
